booth_mult_scheduler: RTL and testbench

- Shares one `booth_multiplier_top` instance between N_REQ requesters.
- Arbitrates round-robin between requesters.
- Sequences the multiplier's serial load protocol: start, then multiplicand on data_in, then multiplier on data_in.
- Waits a fixed latency, then captures the 32-bit product and returns it tagged with the requester ID.

---
 rtl/booth_mult_scheduler_pkg.sv | 23 ++
 rtl/booth_mult_scheduler_rr_arbiter.sv | 34 +++
 rtl/booth_mult_scheduler.sv | 144 ++++++++++++++
 tb/tb_booth_mult_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mult_scheduler_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler: FSM state
// encoding and operand/product/latency constants.
package booth_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_LOAD_A  = 3'd2,
        ST_LOAD_B  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5
    } state_t;

    localparam int DATA_W_DEF   = 16;
    localparam int PROD_W_DEF   = 2 * DATA_W_DEF;
    localparam int MULT_LAT_DEF = 17;

    // True when the state is one in which a new requester may be picked.
    function automatic logic arb_state(input state_t st);
        return (st == ST_IDLE) || (st == ST_CAPTURE);
    endfunction

endpackage

// File: rtl/booth_mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward with
// wrap-around and returns a one-hot grant plus the encoded winner ID.
module booth_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    // Priority search: the requester after 'last' first, 'last' itself lowest.
    always_comb begin
        int   idx;
        logic found_s;
        gnt     = '0;
        gnt_id  = '0;
        idx     = 0;
        found_s = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (enable && !found_s && req[idx]) begin
                found_s  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/booth_mult_scheduler.sv
// Time-shares one serial-load Booth multiplier between N_REQ requesters:
// round-robin grant, start/A/B load sequence, fixed wait, tagged result.
module booth_mult_scheduler
    import booth_mult_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int ID_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic                  busy,
    output logic                  res_valid,
    output logic [ID_W-1:0]       res_id,
    output logic [2*DATA_W-1:0]   res_data,
    output logic                  mult_start,
    output logic [DATA_W-1:0]     mult_data_in,
    input  logic [2*DATA_W-1:0]   mult_product
);

    localparam int CNT_W = $clog2(MULT_LAT + 1);

    state_t               state_r;
    state_t               state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [DATA_W-1:0]    a_r;
    logic [DATA_W-1:0]    b_r;
    logic [ID_W-1:0]      id_r;
    logic [ID_W-1:0]      last_r;
    logic [N_REQ-1:0]     arb_gnt_s;
    logic [ID_W-1:0]      arb_id_s;
    logic                 arb_hit_s;

    booth_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req    (req),
        .last   (last_r),
        .enable (arb_state(state_r)),
        .gnt    (arb_gnt_s),
        .gnt_id (arb_id_s)
    );

    assign arb_hit_s = |arb_gnt_s;

    // Next-state logic for the load/wait/capture sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:    if (arb_hit_s) state_s = ST_START;   else state_s = ST_IDLE;
            ST_START:   state_s = ST_LOAD_A;
            ST_LOAD_A:  state_s = ST_LOAD_B;
            ST_LOAD_B:  state_s = ST_WAIT;
            ST_WAIT:    if (cnt_r == '0) state_s = ST_CAPTURE; else state_s = ST_WAIT;
            ST_CAPTURE: if (arb_hit_s) state_s = ST_START;   else state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latency counter: loaded leaving LOAD_B, so WAIT lasts exactly MULT_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (state_r == ST_LOAD_B) begin
            cnt_r <= CNT_W'(MULT_LAT - 1);
        end else if ((state_r == ST_WAIT) && (cnt_r != '0)) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Winner's operands, ID and RR pointer are captured on the edge entering START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            id_r   <= '0;
            last_r <= ID_W'(N_REQ - 1);
        end else if (state_s == ST_START) begin
            a_r    <= req_a[arb_id_s*DATA_W +: DATA_W];
            b_r    <= req_b[arb_id_s*DATA_W +: DATA_W];
            id_r   <= arb_id_s;
            last_r <= arb_id_s;
        end else begin
            a_r    <= a_r;
            b_r    <= b_r;
            id_r   <= id_r;
            last_r <= last_r;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt          <= '0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_id       <= '0;
            res_data     <= '0;
            mult_start   <= 1'b0;
            mult_data_in <= '0;
        end else begin
            gnt          <= '0;
            busy         <= (state_s != ST_IDLE);
            res_valid    <= 1'b0;
            mult_start   <= 1'b0;
            mult_data_in <= '0;
            case (state_s)
                ST_START: begin
                    gnt        <= arb_gnt_s;
                    mult_start <= 1'b1;
                end
                ST_LOAD_A: mult_data_in <= a_r;
                ST_LOAD_B: mult_data_in <= b_r;
                ST_CAPTURE: begin
                    res_valid <= 1'b1;
                    res_id    <= id_r;
                    res_data  <= mult_product;
                end
                default: begin
                    res_id   <= res_id;
                    res_data <= res_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Directed bench for booth_mult_scheduler with a behavioural serial-load
// multiplier whose product only becomes valid MULT_LAT cycles after LOAD_B.
module tb_booth_mult_scheduler;

    localparam int N_REQ    = 4;
    localparam int DATA_W   = 16;
    localparam int MULT_LAT = 17;
    localparam int ID_W     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic [N_REQ-1:0]        gnt;
    logic                    busy;
    logic                    res_valid;
    logic [ID_W-1:0]         res_id;
    logic [2*DATA_W-1:0]     res_data;
    logic                    mult_start;
    logic [DATA_W-1:0]       mult_data_in;
    logic [2*DATA_W-1:0]     mult_product;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    booth_mult_scheduler #(
        .N_REQ(N_REQ), .DATA_W(DATA_W), .MULT_LAT(MULT_LAT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .mult_start(mult_start),
        .mult_data_in(mult_data_in), .mult_product(mult_product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural multiplier: start, A, B, then product valid after the latency.
    logic signed [DATA_W-1:0] ma, mb;
    int ph, lat;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 0; lat <= 0; ma <= '0; mb <= '0;
            mult_product <= 32'hDEADBEEF;
        end else begin
            if (mult_start) ph <= 1;
            else if (ph == 1) begin ma <= mult_data_in; ph <= 2; end
            else if (ph == 2) begin
                mb <= mult_data_in; ph <= 0; lat <= MULT_LAT - 1;
                mult_product <= 32'hDEADBEEF;
            end
            if (lat != 0) begin
                lat <= lat - 1;
                if (lat == 1) mult_product <= ma * mb;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_op(input int id, input logic [15:0] a, input logic [15:0] b);
        req_a[id*DATA_W +: DATA_W] = a;
        req_b[id*DATA_W +: DATA_W] = b;
    endtask

    task automatic wait_gnt(output int id, output int at);
        id = -1; at = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (gnt != '0) begin
                at = cyc;
                for (int i = 0; i < N_REQ; i++) if (gnt[i]) id = i;
                return;
            end
        end
        check("gnt_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_res(output int id, output logic [31:0] data, output int at);
        id = -1; data = 32'h0; at = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (res_valid) begin
                id = int'(res_id); data = res_data; at = cyc;
                return;
            end
        end
        check("res_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_single(input int id, input logic [15:0] a, input logic [15:0] b,
                              input logic [31:0] p);
        logic early;
        @(negedge clk);
        set_op(id, a, b);
        req[id] = 1'b1;
        @(negedge clk);
        check("single_gnt", 64'(gnt), 64'(4'b0001 << id));
        check("single_start", {63'd0, mult_start}, 64'd1);
        req[id] = 1'b0;
        @(negedge clk);
        check("single_load_a", {47'd0, mult_start, mult_data_in}, {48'd0, a});
        @(negedge clk);
        check("single_load_b", 64'(mult_data_in), 64'(b));
        early = 1'b0;
        for (int k = 4; k < 21; k++) begin
            @(negedge clk);
            if (res_valid || mult_start || gnt != '0) early = 1'b1;
        end
        check("single_quiet_wait", 64'(early), 64'd0);
        @(negedge clk);
        check("single_res", {31'd0, res_valid, 30'd0, res_id}, {31'd0, 1'b1, 30'd0, 2'(id)});
        check("single_data", 64'(res_data), 64'(p));
        @(negedge clk);
        check("single_idle", {62'd0, busy, res_valid}, 64'd0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    vec_t tbl[5];
    int          gid, gat, gprev, rid, rat, rat_prev;
    logic [31:0] rdata;
    logic        seen;
    logic [31:0] simul_p[4];

    initial begin
        tbl[0] = '{0, 16'hFFF6, 16'h000B, 32'hFFFFFF92};
        tbl[1] = '{2, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        tbl[2] = '{1, 16'hFFFF, 16'hFFFF, 32'h00000001};
        tbl[3] = '{3, 16'h8000, 16'h0001, 32'hFFFF8000};
        tbl[4] = '{0, 16'h0000, 16'h1234, 32'h00000000};
        simul_p[0] = 32'h0000000C; simul_p[1] = 32'hFFFFFFDD;
        simul_p[2] = 32'hFFFFD8F0; simul_p[3] = 32'h40000000;

        rst = 1'b1; req = '0; req_a = '0; req_b = '0;
        #1;
        check("reset_outputs", {7'd0, gnt, busy, res_valid, res_id, res_data, mult_start, mult_data_in}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // All four at once: 0,1,2,3 each 21 cycles apart.
        @(negedge clk);
        set_op(0, 16'd3, 16'd4);       set_op(1, 16'hFFFB, 16'd7);
        set_op(2, 16'd100, 16'hFF9C);  set_op(3, 16'h8000, 16'h8000);
        req = 4'b1111;
        gprev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(gid, gat);
            check("simul_order", 64'(gid), 64'(k));
            if (k > 0) check("simul_spacing", 64'(gat - gprev), 64'd21);
            gprev = gat;
            if (gid >= 0) req[gid] = 1'b0;
            wait_res(rid, rdata, rat);
            check("simul_id", 64'(rid), 64'(k));
            check("simul_data", 64'(rdata), 64'(simul_p[k]));
        end

        // Wrap-around: after 3, requesters 3 and 1 -> 1 first; then 2 alone.
        @(negedge clk);
        set_op(1, 16'd2, 16'd5); set_op(3, 16'd9, 16'hFFFF);
        req = 4'b1010;
        wait_gnt(gid, gat);  check("wrap_first", 64'(gid), 64'd1);
        req[1] = 1'b0;
        wait_res(rid, rdata, rat); check("wrap_data1", 64'(rdata), 64'd10);
        wait_gnt(gid, gat);  check("wrap_second", 64'(gid), 64'd3);
        check("wrap_b2b", 64'(gat - rat), 64'd1);
        req[3] = 1'b0;
        wait_res(rid, rdata, rat); check("wrap_data3", 64'(rdata), 64'hFFFFFFF7);
        @(negedge clk);
        set_op(2, 16'd11, 16'd11);
        req = 4'b0100;
        wait_gnt(gid, gat);  check("wrap_third", 64'(gid), 64'd2);
        req[2] = 1'b0;
        wait_res(rid, rdata, rat); check("wrap_data2", 64'(rdata), 64'd121);
        @(negedge clk);

        // Table of single operations with full timing checks.
        foreach (tbl[i]) run_single(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p);

        // Back-to-back: req[2] held high; next grant directly after res_valid.
        @(negedge clk);
        set_op(2, 16'd6, 16'd7);
        req = 4'b0100;
        wait_gnt(gid, gprev);
        wait_res(rid, rdata, rat);
        check("b2b_latency", 64'(rat - gprev), 64'd20);
        wait_gnt(gid, gat);
        check("b2b_id", 64'(gid), 64'd2);
        check("b2b_no_idle", {31'd0, busy, 32'(gat - rat)}, {31'd0, 1'b1, 32'd1});
        req[2] = 1'b0;
        wait_res(rid, rdata, rat);
        check("b2b_data", 64'(rdata), 64'd42);
        @(negedge clk);

        // Reset during WAIT.
        @(negedge clk);
        set_op(1, 16'd5, 16'd5);
        req = 4'b0010;
        wait_gnt(gid, gat);
        req[1] = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {7'd0, gnt, busy, res_valid, res_id, res_data, mult_start, mult_data_in}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (res_valid || busy) seen = 1'b1;
        end
        check("rst_no_result", 64'(seen), 64'd0);
        set_op(0, 16'd1, 16'd2); set_op(3, 16'd3, 16'd3);
        req = 4'b1001;
        wait_gnt(gid, gat);  check("rst_rr_first", 64'(gid), 64'd0);
        req[0] = 1'b0;
        wait_res(rid, rdata, rat);
        wait_gnt(gid, gat);  check("rst_rr_second", 64'(gid), 64'd3);
        req[3] = 1'b0;
        wait_res(rid, rdata, rat); check("rst_rr_data", 64'(rdata), 64'd9);
        @(negedge clk);

        // Withdrawn request: req[1] pulses while busy and is never granted.
        @(negedge clk);
        set_op(0, 16'd2, 16'd3);
        req = 4'b0001;
        wait_gnt(gid, gat);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        seen = 1'b0; rdata = 32'h0; rat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt[1]) seen = 1'b1;
            if (res_valid) begin rdata = res_data; rat = cyc; break; end
        end
        check("withdraw_data", 64'(rdata), 64'd6);
        repeat (3) begin
            @(negedge clk);
            if (gnt[1] || busy) seen = 1'b1;
        end
        check("withdraw_never_gnt", 64'(seen), 64'd0);
        check("withdraw_idle", {62'd0, busy, mult_start}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case something upstream stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1);
    end

endmodule
